alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have: in_valid  input  1  decoded-stage instruction present.
REQ-004 SHALL have: in_ready  output  1  stage accepts instruction this cycle.
REQ-005 SHALL have: instr  input  32  MIPS instruction word.
REQ-006 SHALL have: rs_data, rt_data  input  32 each  register operands.
REQ-007 SHALL have: flush  input  1  synchronous kill of held entry.
REQ-008 SHALL have: ex_ready  input  1  execute stage consumes out entry.
REQ-009 SHALL have: out_valid  output  1  entry held for execute.
REQ-010 SHALL have: ALUCtl  output  5  ALU operation code.
REQ-011 SHALL have: Sign  output  1  signed compare/overflow select.
REQ-012 SHALL have: in1, in2  output  32 each  ALU operands; shifts move in2 by in1[4:0].
REQ-013 SHALL have: wr_reg  output  5  destination register.
REQ-014 SHALL have: illegal  output  1  held entry not decodable.
REQ-015 SHALL have: issue_count  output  16  count of entries consumed by execute.

Function
REQ-016 SHALL assert in_ready = !out_valid || ex_ready, combinationally.
REQ-017 SHALL capture decoded fields into output registers on clk edge when in_valid && in_ready && !flush; out_valid <= 1; latency exactly one cycle.
REQ-018 SHALL clear out_valid when ex_ready && out_valid and no new accept occurs in the same cycle; simultaneous consume + accept SHALL keep out_valid=1 with new contents.
REQ-019 SHALL, on flush=1, clear out_valid next edge regardless of in_valid/ex_ready; flush beats accept; issue_count not incremented.
REQ-020 SHALL hold all outputs stable while out_valid && !ex_ready.
REQ-021 SHALL decode opcode 0 by funct: 20 add 00010/S1; 21 addu 00010/S0; 22 sub 00110/S1; 23 subu 00110/S0; 24 and 00000; 25 or 00001; 26 xor 01101; 27 nor 01100; 2A slt 00111/S1; 2B sltu 00111/S0 (hex funct; Sign=0 unless stated).
REQ-022 SHALL decode shifts: 00 sll 10000, 02 srl 11000, 03 sra 11001 with in1={27'b0,shamt}; 04 sllv, 06 srlv, 07 srav same codes with in1=rs_data; in2=rt_data.
REQ-023 SHALL for non-shift R-type drive in1=rs_data, in2=rt_data, wr_reg=instr[15:11].
REQ-024 SHALL flag any other opcode/funct as illegal=1, ALUCtl=00000, Sign=0, wr_reg=0, in1=in2=0, still handshaken normally.
REQ-025 SHALL increment issue_count by 1 per cycle with out_valid && ex_ready && !flush, wrapping FFFF -> 0000.

Reset
REQ-026 SHALL, while reset=0, asynchronously force out_valid=0, ALUCtl=0, Sign=0, in1=0, in2=0, wr_reg=0, illegal=0, issue_count=0; held entry discarded mid-operation.
REQ-027 SHALL drive in_ready=1 during and immediately after reset.

Configuration
REQ-028 SHALL support macro ALU_ISSUE_IMM_EN; defined: I-type decode, in1=rs_data, wr_reg=instr[20:16]: 08 addi 00010/S1 sext; 09 addiu 00010/S0 sext; 0A slti 00111/S1 sext; 0B sltiu 00111/S0 sext; 0C andi 00000 zext; 0D ori 00001 zext; 0E xori 01101 zext; 0F lui 10000 with in1=16, in2=zext imm.
REQ-029 SHALL, without ALU_ISSUE_IMM_EN, treat all nonzero opcodes as illegal per REQ-024.

Verification
REQ-030 SHALL test: reset=0 mid-stall with out_valid=1 -> all outputs 0 asynchronously, in_ready=1.
REQ-031 SHALL test: instr=0x00851020 (add $2,$4,$5), rs=7, rt=0xFFFFFFFE, ex_ready=1 -> next cycle ALUCtl=00010, Sign=1, in1=7, in2=0xFFFFFFFE, wr_reg=2.
REQ-032 SHALL test: instr=0x00041083 (sra $2,$4,2) -> ALUCtl=11001, in1=2, in2=rt_data.
REQ-033 SHALL test: ex_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, issue_count unchanged; then ex_ready=1 -> issue_count+1.
REQ-034 SHALL test: flush=1 with in_valid=1, ex_ready=1 -> out_valid=0 next cycle, issue_count unchanged.
REQ-035 SHALL test: instr=0x3C011234 (lui) -> with ALU_ISSUE_IMM_EN ALUCtl=10000, in1=16, in2=0x1234, wr_reg=1; without it illegal=1.

Source files
------------

// File: rtl/alu_issue.sv
// ALU issue stage: decodes a MIPS instruction into ALU controls/operands and holds it for execute.
// Optional I-type decode is enabled by defining ALU_ISSUE_IMM_EN.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        out_valid,
  output logic [4:0]  ALUCtl,
  output logic        Sign,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  wr_reg,
  output logic        illegal,
  output logic [15:0] issue_count
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned NW = 16;

  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [4:0]    shamt;
  logic [4:0]    rd;
  logic [15:0]   imm;
  logic          accept;
  logic          consume;

  logic [CW-1:0] d_ctl;
  logic          d_sign;
  logic [DW-1:0] d_in1;
  logic [DW-1:0] d_in2;
  logic [4:0]    d_wr;
  logic          d_ill;

  logic          unused_ok;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign shamt     = instr[10:6];
  assign rd        = instr[15:11];
  assign imm       = instr[15:0];
  assign unused_ok = ^instr[25:16];

  assign in_ready = !out_valid || ex_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = out_valid && ex_ready && !flush;

  // Instruction decode; anything unrecognised becomes an all-zero illegal entry.
  always_comb begin
    d_ctl  = '0;
    d_sign = 1'b0;
    d_in1  = '0;
    d_in2  = '0;
    d_wr   = '0;
    d_ill  = 1'b1;
    if (opcode == 6'h00) begin
      d_ill = 1'b0;
      d_wr  = rd;
      d_in1 = rs_data;
      d_in2 = rt_data;
      case (funct)
        6'h20: begin d_ctl = 5'b00010; d_sign = 1'b1; end
        6'h21: d_ctl = 5'b00010;
        6'h22: begin d_ctl = 5'b00110; d_sign = 1'b1; end
        6'h23: d_ctl = 5'b00110;
        6'h24: d_ctl = 5'b00000;
        6'h25: d_ctl = 5'b00001;
        6'h26: d_ctl = 5'b01101;
        6'h27: d_ctl = 5'b01100;
        6'h2A: begin d_ctl = 5'b00111; d_sign = 1'b1; end
        6'h2B: d_ctl = 5'b00111;
        6'h00: begin d_ctl = 5'b10000; d_in1 = DW'(shamt); end
        6'h02: begin d_ctl = 5'b11000; d_in1 = DW'(shamt); end
        6'h03: begin d_ctl = 5'b11001; d_in1 = DW'(shamt); end
        6'h04: d_ctl = 5'b10000;
        6'h06: d_ctl = 5'b11000;
        6'h07: d_ctl = 5'b11001;
        default: begin
          d_ill = 1'b1;
          d_wr  = '0;
          d_in1 = '0;
          d_in2 = '0;
        end
      endcase
    end
`ifdef ALU_ISSUE_IMM_EN
    else if (opcode[5:3] == 3'b001) begin
      d_ill = 1'b0;
      d_wr  = instr[20:16];
      d_in1 = rs_data;
      case (opcode[2:0])
        3'h0: begin d_ctl = 5'b00010; d_sign = 1'b1; d_in2 = DW'($signed(imm)); end
        3'h1: begin d_ctl = 5'b00010; d_in2 = DW'($signed(imm)); end
        3'h2: begin d_ctl = 5'b00111; d_sign = 1'b1; d_in2 = DW'($signed(imm)); end
        3'h3: begin d_ctl = 5'b00111; d_in2 = DW'($signed(imm)); end
        3'h4: begin d_ctl = 5'b00000; d_in2 = DW'(imm); end
        3'h5: begin d_ctl = 5'b00001; d_in2 = DW'(imm); end
        3'h6: begin d_ctl = 5'b01101; d_in2 = DW'(imm); end
        default: begin d_ctl = 5'b10000; d_in1 = DW'(16); d_in2 = DW'(imm); end
      endcase
    end
`endif
  end

  // Holding register; flush outranks accept, accept outranks drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      ALUCtl      <= '0;
      Sign        <= 1'b0;
      in1         <= '0;
      in2         <= '0;
      wr_reg      <= '0;
      illegal     <= 1'b0;
      issue_count <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        ALUCtl    <= d_ctl;
        Sign      <= d_sign;
        in1       <= d_in1;
        in2       <= d_in2;
        wr_reg    <= d_wr;
        illegal   <= d_ill;
      end else if (ex_ready) begin
        out_valid <= 1'b0;
      end
      if (consume) issue_count <= issue_count + NW'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed spec vectors plus randomized traffic vs a transaction model.
module tb_alu_issue;

  logic        clk, reset, in_valid, in_ready, flush, ex_ready, out_valid, Sign, illegal;
  logic [31:0] instr, rs_data, rt_data, in1, in2;
  logic [4:0]  ALUCtl, wr_reg;
  logic [15:0] issue_count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  ctl;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wr;
    logic        ill;
  } ent_t;

  logic        m_valid;
  ent_t        m_ent;
  logic [15:0] m_count;
  logic [15:0] c0;

  alu_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .ex_ready(ex_ready), .out_valid(out_valid), .ALUCtl(ALUCtl), .Sign(Sign),
    .in1(in1), .in2(in2), .wr_reg(wr_reg), .illegal(illegal), .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written from the instruction tables.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    ent_t e;
    logic [5:0] op, fn;
    logic [15:0] im;
    logic [31:0] shamt32;
    e  = '0;
    e.ill = 1'b1;
    op = ins[31:26];
    fn = ins[5:0];
    im = ins[15:0];
    shamt32 = {27'd0, ins[10:6]};
    if (op == 6'h00) begin
      e = '{ctl: 5'b00000, sign: 1'b0, a: rs, b: rt, wr: ins[15:11], ill: 1'b0};
      case (fn)
        6'h20: begin e.ctl = 5'd2;  e.sign = 1'b1; end
        6'h21: e.ctl = 5'd2;
        6'h22: begin e.ctl = 5'd6;  e.sign = 1'b1; end
        6'h23: e.ctl = 5'd6;
        6'h24: e.ctl = 5'd0;
        6'h25: e.ctl = 5'd1;
        6'h26: e.ctl = 5'd13;
        6'h27: e.ctl = 5'd12;
        6'h2A: begin e.ctl = 5'd7;  e.sign = 1'b1; end
        6'h2B: e.ctl = 5'd7;
        6'h00: begin e.ctl = 5'd16; e.a = shamt32; end
        6'h02: begin e.ctl = 5'd24; e.a = shamt32; end
        6'h03: begin e.ctl = 5'd25; e.a = shamt32; end
        6'h04: e.ctl = 5'd16;
        6'h06: e.ctl = 5'd24;
        6'h07: e.ctl = 5'd25;
        default: begin e = '0; e.ill = 1'b1; end
      endcase
    end
`ifdef ALU_ISSUE_IMM_EN
    else if (op >= 6'h08 && op <= 6'h0F) begin
      e = '{ctl: 5'b00000, sign: 1'b0, a: rs, b: {16'd0, im}, wr: ins[20:16], ill: 1'b0};
      if (op <= 6'h0B) e.b = {{16{im[15]}}, im};
      case (op)
        6'h08: begin e.ctl = 5'd2; e.sign = 1'b1; end
        6'h09: e.ctl = 5'd2;
        6'h0A: begin e.ctl = 5'd7; e.sign = 1'b1; end
        6'h0B: e.ctl = 5'd7;
        6'h0C: e.ctl = 5'd0;
        6'h0D: e.ctl = 5'd1;
        6'h0E: e.ctl = 5'd13;
        default: begin e.ctl = 5'd16; e.a = 32'd16; end
      endcase
    end
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl, input logic er);
    in_valid = iv; instr = ins; rs_data = rs; rt_data = rt; flush = fl; ex_ready = er;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ex_ready));
    chk({tag, ".issue_count"}, 32'(issue_count), 32'(m_count));
    if (m_valid) begin
      chk({tag, ".ALUCtl"}, 32'(ALUCtl), 32'(m_ent.ctl));
      chk({tag, ".Sign"}, 32'(Sign), 32'(m_ent.sign));
      chk({tag, ".in1"}, in1, m_ent.a);
      chk({tag, ".in2"}, in2, m_ent.b);
      chk({tag, ".wr_reg"}, 32'(wr_reg), 32'(m_ent.wr));
      chk({tag, ".illegal"}, 32'(illegal), 32'(m_ent.ill));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".ALUCtl"}, 32'(ALUCtl), 32'd0);
    chk({tag, ".Sign"}, 32'(Sign), 32'd0);
    chk({tag, ".in1"}, in1, 32'd0);
    chk({tag, ".in2"}, in2, 32'd0);
    chk({tag, ".wr_reg"}, 32'(wr_reg), 32'd0);
    chk({tag, ".illegal"}, 32'(illegal), 32'd0);
    chk({tag, ".issue_count"}, 32'(issue_count), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  // One clock edge: advance the transaction model with the inputs seen at the edge, then compare.
  task automatic tick(input string tag);
    logic rdy;
    @(posedge clk);
    rdy = !m_valid || ex_ready;
    if (flush) begin
      m_valid = 1'b0;
    end else begin
      if (m_valid && ex_ready) m_count = m_count + 16'd1;
      if (in_valid && rdy) begin
        m_valid = 1'b1;
        m_ent   = ref_decode(instr, rs_data, rt_data);
      end else if (m_valid && ex_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_model(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0] fl [16];
    int r;
    fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    ins = $urandom;
    r = $urandom_range(0, 9);
    if (r < 5) begin
      ins[31:26] = 6'h00;
      ins[5:0] = fl[$urandom_range(0, 15)];
    end else if (r == 5) begin
      ins[31:26] = 6'h00;
    end else if (r < 9) begin
      ins[31:26] = 6'(8 + $urandom_range(0, 7));
    end
    return ins;
  endfunction

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    m_valid = 1'b0; m_ent = '0; m_count = '0;
    #3;
    check_zero("reset");
    #9 reset = 1'b1;
    #1 chk("post_reset.in_ready", 32'(in_ready), 32'd1);

    drive(1'b1, 32'h00851020, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b1);
    tick("add");
    chk("add.ALUCtl", 32'(ALUCtl), 32'b00010);
    chk("add.Sign", 32'(Sign), 32'd1);
    chk("add.in1", in1, 32'd7);
    chk("add.in2", in2, 32'hFFFFFFFE);
    chk("add.wr_reg", 32'(wr_reg), 32'd2);

    drive(1'b1, 32'h00041083, 32'h12345678, 32'h800000F0, 1'b0, 1'b1);
    tick("sra");
    chk("sra.ALUCtl", 32'(ALUCtl), 32'b11001);
    chk("sra.in1", in1, 32'd2);
    chk("sra.in2", in2, 32'h800000F0);

    c0 = m_count;
    drive(1'b1, 32'h00A62022, 32'd3, 32'd4, 1'b0, 1'b0);
    #1 chk("stall.in_ready", 32'(in_ready), 32'd0);
    repeat (3) tick("stall");
    chk("stall.ALUCtl", 32'(ALUCtl), 32'b11001);
    chk("stall.in1", in1, 32'd2);
    chk("stall.issue_count", 32'(issue_count), 32'(c0));
    ex_ready = 1'b1;
    tick("release");
    chk("release.issue_count", 32'(issue_count), 32'(c0 + 16'd1));
    chk("release.ALUCtl", 32'(ALUCtl), 32'b00110);

    drive(1'b1, 32'h00851020, 32'd1, 32'd2, 1'b1, 1'b1);
    tick("flush");
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.issue_count", 32'(issue_count), 32'(c0 + 16'd1));

    drive(1'b1, 32'h3C011234, 32'd5, 32'd6, 1'b0, 1'b1);
    tick("lui");
`ifdef ALU_ISSUE_IMM_EN
    chk("lui.ALUCtl", 32'(ALUCtl), 32'b10000);
    chk("lui.in1", in1, 32'd16);
    chk("lui.in2", in2, 32'h1234);
    chk("lui.wr_reg", 32'(wr_reg), 32'd1);
    chk("lui.illegal", 32'(illegal), 32'd0);
`else
    chk("lui.illegal", 32'(illegal), 32'd1);
    chk("lui.ALUCtl", 32'(ALUCtl), 32'd0);
    chk("lui.in1", in1, 32'd0);
    chk("lui.wr_reg", 32'(wr_reg), 32'd0);
`endif

    drive(1'b1, 32'h00851020, 32'd9, 32'd9, 1'b0, 1'b1);
    tick("pre_async");
    drive(1'b1, 32'h00851021, 32'd1, 32'd1, 1'b0, 1'b0);
    tick("held");
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    m_valid = 1'b0; m_ent = '0; m_count = '0;
    @(negedge clk) reset = 1'b1;
    #1 chk("after_async.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
